// File: rtl/hc595_frame_receiver.sv
// HC595 link receiver: resynchronises DS/SH_CP/ST_CP, rebuilds 16-bit words,
// decodes segments to digits and keeps an 8-position frame buffer.
module hc595_frame_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_PULSE   = 2
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        DS,
   input  logic        SH_CP,
   input  logic        ST_CP,
   output logic        word_valid,
   output logic [15:0] raw_word,
   output logic [31:0] digits,
   output logic [7:0]  dps,
   output logic        scan_done,
   output logic        frame_err,
   output logic        sel_err,
   output logic        code_err,
   output logic [15:0] word_cnt
);

   if (SYNC_STAGES < 2 || MIN_PULSE < 1) begin : g_bad_param
      $error("hc595_frame_receiver: SYNC_STAGES must be >=2, MIN_PULSE >=1");
   end

   logic [SYNC_STAGES-1:0] ds_s, sh_s, st_s;
   logic        sh_d, st_d, ds_q, sh_rise, st_rise;
   logic [15:0] sreg;
   logic [4:0]  bit_cnt;
   logic [7:0]  seen;
   logic [7:0]  seen_nxt;
   logic [2:0]  pos;
   logic [3:0]  dec;
   logic        one_low;

   function automatic logic [3:0] seg_decode(input logic [6:0] s);
      case (s)
         7'h7E:   seg_decode = 4'h0;
         7'h30:   seg_decode = 4'h1;
         7'h6D:   seg_decode = 4'h2;
         7'h79:   seg_decode = 4'h3;
         7'h33:   seg_decode = 4'h4;
         7'h5B:   seg_decode = 4'h5;
         7'h5F:   seg_decode = 4'h6;
         7'h70:   seg_decode = 4'h7;
         7'h7F:   seg_decode = 4'h8;
         7'h7B:   seg_decode = 4'h9;
         7'h01:   seg_decode = 4'hA;
         default: seg_decode = 4'hF;
      endcase
   endfunction

   // Candidate word is always the pre-shift sreg, matching the 74HC595 latch.
   always_comb begin
      pos = '0;
      for (int i = 0; i < 8; i++) begin
         if (!sreg[i]) pos = 3'(i);
      end
      one_low  = $onehot(~sreg[7:0]);
      dec      = seg_decode(sreg[14:8]);
      seen_nxt = seen | (8'd1 << pos);
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         ds_s    <= '0;
         sh_s    <= '0;
         st_s    <= '0;
         sh_d    <= 1'b0;
         st_d    <= 1'b0;
         ds_q    <= 1'b0;
         sh_rise <= 1'b0;
         st_rise <= 1'b0;
      end else begin
         ds_s    <= {ds_s[SYNC_STAGES-2:0], DS};
         sh_s    <= {sh_s[SYNC_STAGES-2:0], SH_CP};
         st_s    <= {st_s[SYNC_STAGES-2:0], ST_CP};
         sh_d    <= sh_s[SYNC_STAGES-1];
         st_d    <= st_s[SYNC_STAGES-1];
         ds_q    <= ds_s[SYNC_STAGES-1];
         sh_rise <= sh_s[SYNC_STAGES-1] & ~sh_d;
         st_rise <= st_s[SYNC_STAGES-1] & ~st_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         sreg       <= '0;
         bit_cnt    <= '0;
         seen       <= '0;
         raw_word   <= '0;
         digits     <= 32'hFFFF_FFFF;
         dps        <= '0;
         word_cnt   <= '0;
         word_valid <= 1'b0;
         scan_done  <= 1'b0;
         frame_err  <= 1'b0;
         sel_err    <= 1'b0;
         code_err   <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         scan_done  <= 1'b0;
         frame_err  <= 1'b0;
         sel_err    <= 1'b0;
         code_err   <= 1'b0;
         if (sh_rise) sreg <= {sreg[14:0], ds_q};
         if (st_rise) begin
            bit_cnt <= sh_rise ? 5'd1 : 5'd0;
            if (bit_cnt != 5'd16) begin
               frame_err <= 1'b1;
            end else if (!one_low) begin
               sel_err <= 1'b1;
            end else begin
               digits[4*pos +: 4] <= dec;
               dps[pos]   <= sreg[15];
               raw_word   <= sreg;
               word_valid <= 1'b1;
               code_err   <= (dec == 4'hF);
               word_cnt   <= word_cnt + 16'd1;
               if (seen_nxt == 8'hFF) begin
                  scan_done <= 1'b1;
                  seen      <= '0;
               end else begin
                  seen <= seen_nxt;
               end
            end
         end else if (sh_rise && bit_cnt != 5'd31) begin
            bit_cnt <= bit_cnt + 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_hc595_frame_receiver.sv
// Bench for hc595_frame_receiver: word-level model plus per-cycle compare
// against the DUT, with literal checkpoints after each directed scenario.
module tb_hc595_frame_receiver;

   localparam int SYNC = 2;
   localparam int LAT  = SYNC + 2;

   logic        clk = 1'b0;
   logic        Reset_n, DS, SH_CP, ST_CP;
   logic        word_valid, scan_done, frame_err, sel_err, code_err;
   logic [15:0] raw_word, word_cnt;
   logic [31:0] digits;
   logic [7:0]  dps;

   hc595_frame_receiver #(.SYNC_STAGES(SYNC), .MIN_PULSE(2)) dut (
      .Clk(clk), .Reset_n(Reset_n), .DS(DS), .SH_CP(SH_CP), .ST_CP(ST_CP),
      .word_valid(word_valid), .raw_word(raw_word), .digits(digits),
      .dps(dps), .scan_done(scan_done), .frame_err(frame_err),
      .sel_err(sel_err), .code_err(code_err), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      bit          wv, fe, se, ce, sd;
      logic [15:0] raw;
      logic [31:0] dig;
      logic [7:0]  dp;
      logic [15:0] cnt;
   } ev_t;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   scan_cnt = 0;
   bit   chk_en = 0;
   ev_t  evq[$];
   bit   bq[$];

   logic [15:0] m_raw = '0;
   logic [31:0] m_dig = 32'hFFFF_FFFF;
   logic [7:0]  m_dps = '0;
   logic [15:0] m_cnt = '0;
   logic [7:0]  m_seen = '0;

   logic [15:0] c_raw = '0;
   logic [31:0] c_dig = 32'hFFFF_FFFF;
   logic [7:0]  c_dps = '0;
   logic [15:0] c_cnt = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] model_dec(logic [6:0] s);
      logic [6:0] tbl [11];
      tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
              7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h01};
      for (int i = 0; i < 11; i++)
         if (tbl[i] == s) return 4'(i);
      return 4'hF;
   endfunction

   always @(negedge clk) begin
      bit wv, fe, se, ce, sd;
      wv = 0; fe = 0; se = 0; ce = 0; sd = 0;
      if (chk_en) begin
         while (evq.size() > 0 && evq[0].due <= cyc) begin
            ev_t e;
            e = evq.pop_front();
            if (e.due < cyc) chk("ev_late", 32'(e.due), 32'(cyc));
            wv = e.wv; fe = e.fe; se = e.se; ce = e.ce; sd = e.sd;
            c_raw = e.raw; c_dig = e.dig; c_dps = e.dp; c_cnt = e.cnt;
         end
         if (scan_done === 1'b1) scan_cnt++;
         chk("word_valid", 32'(word_valid), 32'(wv));
         chk("frame_err", 32'(frame_err), 32'(fe));
         chk("sel_err", 32'(sel_err), 32'(se));
         chk("code_err", 32'(code_err), 32'(ce));
         chk("scan_done", 32'(scan_done), 32'(sd));
         chk("raw_word", 32'(raw_word), 32'(c_raw));
         chk("digits", digits, c_dig);
         chk("dps", 32'(dps), 32'(c_dps));
         chk("word_cnt", 32'(word_cnt), 32'(c_cnt));
      end
   end

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_state(bit wv, bit fe, bit se, bit ce, bit sd);
      ev_t e;
      e.due = cyc + LAT;
      e.wv = wv; e.fe = fe; e.se = se; e.ce = ce; e.sd = sd;
      e.raw = m_raw; e.dig = m_dig; e.dp = m_dps; e.cnt = m_cnt;
      evq.push_back(e);
   endtask

   // Word-level view: whatever bits arrived since the last latch form the frame.
   task automatic model_latch();
      logic [15:0] w;
      int zeros, p;
      logic [3:0] d;
      bit sd;
      if (bq.size() != 16) begin
         push_state(0, 1, 0, 0, 0);
         return;
      end
      w = '0;
      foreach (bq[i]) w = {w[14:0], bq[i]};
      zeros = 0; p = 0;
      for (int i = 0; i < 8; i++)
         if (!w[i]) begin zeros++; p = i; end
      if (zeros != 1) begin
         push_state(0, 0, 1, 0, 0);
         return;
      end
      d = model_dec(w[14:8]);
      m_dig[4*p +: 4] = d;
      m_dps[p] = w[15];
      m_raw = w;
      m_cnt = m_cnt + 16'd1;
      m_seen[p] = 1'b1;
      sd = (m_seen == 8'hFF);
      if (sd) m_seen = '0;
      push_state(1, 0, 0, d == 4'hF, sd);
   endtask

   task automatic shift_bit(bit b);
      DS = b;
      idle(2);
      SH_CP = 1'b1;
      bq.push_back(b);
      idle(2);
      SH_CP = 1'b0;
   endtask

   task automatic send_bits(logic [15:0] w, int n);
      for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
   endtask

   task automatic latch(bit with_shift, bit b);
      if (with_shift) DS = b;
      idle(2);
      ST_CP = 1'b1;
      if (with_shift) SH_CP = 1'b1;
      model_latch();
      bq.delete();
      if (with_shift) bq.push_back(b);
      idle(2);
      ST_CP = 1'b0;
      SH_CP = 1'b0;
      idle(2);
   endtask

   task automatic send_word(logic [15:0] w);
      send_bits(w, 16);
      latch(0, 0);
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      bq.delete();
      m_raw = '0; m_dig = 32'hFFFF_FFFF; m_dps = '0; m_cnt = '0; m_seen = '0;
      begin
         ev_t e;
         e.due = cyc + 1;
         e.wv = 0; e.fe = 0; e.se = 0; e.ce = 0; e.sd = 0;
         e.raw = m_raw; e.dig = m_dig; e.dp = m_dps; e.cnt = m_cnt;
         evq.push_back(e);
      end
      idle(1);
      Reset_n = 1'b1;
   endtask

   logic [7:0] segs [8];

   initial begin
      segs = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70};
      DS = 0; SH_CP = 0; ST_CP = 0; Reset_n = 0;
      idle(3);
      Reset_n = 1;
      chk_en = 1;
      idle(1);
      chk("rst_digits", digits, 32'hFFFF_FFFF);
      chk("rst_cnt", 32'(word_cnt), 32'h0);

      send_word(16'h7EFE);
      idle(6);
      chk("t1_raw", 32'(raw_word), 32'h7EFE);
      chk("t1_digits", digits, 32'hFFFF_FFF0);
      chk("t1_dps", 32'(dps), 32'h0);
      chk("t1_cnt", 32'(word_cnt), 32'h1);

      do_reset();
      idle(2);
      scan_cnt = 0;
      for (int p = 0; p < 8; p++) begin
         logic [7:0] s;
         s = segs[p] | ((p == 3) ? 8'h80 : 8'h00);
         send_word({s, ~(8'd1 << p)});
      end
      idle(6);
      chk("t2_digits", digits, 32'h7654_3210);
      chk("t2_dps", 32'(dps), 32'h08);
      chk("t2_cnt", 32'(word_cnt), 32'd8);
      chk("t2_scans", 32'(scan_cnt), 32'd1);

      send_bits(16'h30F7, 15);
      latch(0, 0);
      idle(4);
      chk("t3_digits_kept", digits, 32'h7654_3210);
      send_word(16'h30F7);
      idle(6);
      chk("t3_digits", digits, 32'h7654_1210);

      send_word(16'h33FC);
      send_word(16'h33FF);
      send_word(16'h00FB);
      send_word(16'h01EF);
      idle(6);
      chk("t4_digits", digits, 32'h765A_1F10);
      chk("t4_cnt", 32'(word_cnt), 32'd11);

      send_bits(16'h5BDF, 16);
      latch(1, 1'b0);
      send_bits(16'h6DBF, 15);
      latch(0, 0);
      idle(6);
      chk("t5_digits", digits, 32'h725A_1F10);
      chk("t5_raw", 32'(raw_word), 32'h6DBF);
      chk("t5_cnt", 32'(word_cnt), 32'd13);

      send_bits(16'h00A5, 8);
      do_reset();
      idle(4);
      send_word(16'h79F7);
      idle(6);
      chk("t6_digits", digits, 32'hFFFF_3FFF);
      chk("t6_raw", 32'(raw_word), 32'h79F7);
      chk("t6_cnt", 32'(word_cnt), 32'd1);

      idle(10);
      chk("ev_drained", 32'(evq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
